// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write port arbiter (pipeline writeback vs ECALL result)
// with starvation-bounded priority, a one-cycle registered write port and a pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_req_valid,
  input  logic [4:0]  wb_req_addr,
  input  logic [63:0] wb_req_data,
  output logic        wb_req_ready,
  input  logic        ec_req_valid,
  input  logic [4:0]  ec_req_addr,
  input  logic [63:0] ec_req_data,
  output logic        ec_req_ready,
  input  logic        reserve_valid,
  input  logic [4:0]  reserve_addr,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_addr,
  output logic [63:0] rf_write_data,
  output logic [31:0] pending_mask,
  output logic [2:0]  starve_count
);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..7");
    end
  endgenerate

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {PRIO_EC, PRIO_WB} state_t;

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] pend_q, pend_d;

  logic        grant;
  logic [4:0]  gnt_addr;
  logic [63:0] gnt_data;

  // Readies are gated by reset so nothing can handshake while the block is held in reset.
  assign wb_req_ready = reset & wb_req_valid & (~ec_req_valid | (state_q == PRIO_WB));
  assign ec_req_ready = reset & ec_req_valid & ~wb_req_ready;
  assign grant        = wb_req_ready | ec_req_ready;
  assign gnt_addr     = wb_req_ready ? wb_req_addr : ec_req_addr;
  assign gnt_data     = wb_req_ready ? wb_req_data : ec_req_data;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (wb_req_ready) begin
      starve_d = 3'd0;
      state_d  = PRIO_EC;
    end else if (ec_req_ready && wb_req_valid) begin
      if (starve_q < LIMIT) starve_d = starve_q + 3'd1;
      if (starve_d == LIMIT) state_d = PRIO_WB;
    end
  end

  // x0 requests are accepted but never strobe the file; address/data only move on real writes.
  always_comb begin
    we_d    = grant && (gnt_addr != 5'd0);
    waddr_d = we_d ? gnt_addr : waddr_q;
    wdata_d = we_d ? gnt_data : wdata_q;
  end

  // Clear of the retiring write happens first so a same-edge reserve of that register wins.
  always_comb begin
    pend_d = pend_q;
    if (we_q) pend_d[waddr_q] = 1'b0;
    if (reserve_valid) pend_d[reserve_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= PRIO_EC;
      starve_q <= 3'd0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 64'd0;
      pend_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign pending_mask    = pend_q;
  assign starve_count    = starve_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench: a behavioural model schedules expected writes into a queue,
// a negedge monitor pops and compares them along with readies, scoreboard and starve count.
module tb_regfile_write_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_req_valid, ec_req_valid, reserve_valid;
  logic [4:0]  wb_req_addr, ec_req_addr, reserve_addr;
  logic [63:0] wb_req_data, ec_req_data;
  logic        wb_req_ready, ec_req_ready, rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic [31:0] pending_mask;
  logic [2:0]  starve_count;

  regfile_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_req_valid(wb_req_valid), .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data),
    .wb_req_ready(wb_req_ready),
    .ec_req_valid(ec_req_valid), .ec_req_addr(ec_req_addr), .ec_req_data(ec_req_data),
    .ec_req_ready(ec_req_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .pending_mask(pending_mask), .starve_count(starve_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    int          due;
  } wr_t;

  wr_t         expq[$];
  int          cyc = 0;
  int          nchk = 0, npass = 0;
  int          losses = 0;
  logic [31:0] pend = '0;
  logic        due_v = 1'b0;
  logic [4:0]  due_a = '0;
  logic [4:0]  last_a = '0;
  logic [63:0] last_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Reference: WB loses conflicts until it has lost LIM times in a row, then it wins once.
  always @(posedge clk) begin
    bit g_wb, g_ec;
    logic [4:0]  a;
    logic [63:0] d;
    cyc++;
    if (!reset) begin
      pend = '0; losses = 0; due_v = 0; last_a = '0; last_d = '0;
      expq.delete();
    end else begin
      if (due_v) pend[due_a] = 1'b0;
      if (reserve_valid) pend[reserve_addr] = 1'b1;
      pend[0] = 1'b0;
      due_v = 0;
      g_wb = wb_req_valid && (!ec_req_valid || losses >= LIM);
      g_ec = ec_req_valid && !g_wb;
      if (g_wb) losses = 0;
      else if (g_ec && wb_req_valid) losses = (losses + 1 > LIM) ? LIM : losses + 1;
      if (g_wb || g_ec) begin
        a = g_wb ? wb_req_addr : ec_req_addr;
        d = g_wb ? wb_req_data : ec_req_data;
        if (a != 0) begin
          expq.push_back('{a, d, cyc});
          due_v = 1; due_a = a; last_a = a; last_d = d;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit has_due;
    if (cyc > 0) begin
      chk("wb_ready", wb_req_ready,
          reset && wb_req_valid && (!ec_req_valid || losses >= LIM));
      chk("ec_ready", ec_req_ready,
          reset && ec_req_valid && (!wb_req_valid || losses < LIM));
      chk("pending_mask", pending_mask, pend);
      chk("starve_count", starve_count, losses);
      while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
      has_due = expq.size() > 0 && expq[0].due == cyc;
      chk("wr_en", rf_write_enable, has_due);
      if (has_due) begin
        chk("wr_addr", rf_write_addr, expq[0].a);
        chk("wr_data", rf_write_data, expq[0].d);
        void'(expq.pop_front());
      end else begin
        chk("hold_addr", rf_write_addr, last_a);
        chk("hold_data", rf_write_data, last_d);
      end
    end
  end

  task automatic drive(input logic rst, input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                       input logic ev, input logic [4:0] ea, input logic [63:0] ed,
                       input logic rv, input logic [4:0] ra);
    reset = rst;
    wb_req_valid = wv; wb_req_addr = wa; wb_req_data = wd;
    ec_req_valid = ev; ec_req_addr = ea; ec_req_data = ed;
    reserve_valid = rv; reserve_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // lone WB request
    drive(1, 1, 5, 64'h1234, 0, 0, 0, 0, 0);
    idle(2);
    // sustained conflict: EC x4, then WB forced through, then EC again
    for (int i = 0; i < 6; i++) drive(1, 1, 3, 64'hB0 + i, 1, 10, 64'hE0 + i, 0, 0);
    idle(2);
    // ECALL to x0 accepted with no write
    drive(1, 0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
    idle(2);
    // reserve x7, write it two cycles later
    drive(1, 0, 0, 0, 0, 0, 0, 1, 7);
    idle(1);
    drive(1, 1, 7, 64'h77, 0, 0, 0, 0, 0);
    idle(3);
    // reserve x9 in the same cycle its retiring write is on the port
    drive(1, 0, 0, 0, 0, 0, 0, 1, 9);
    drive(1, 1, 9, 64'h99, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 9);
    idle(2);
    // write in flight, then reset, then a fresh request
    drive(1, 0, 0, 0, 0, 0, 0, 1, 12);
    drive(1, 1, 12, 64'hC0FFEE, 0, 0, 0, 0, 0);
    drive(0, 1, 13, 64'h5555, 1, 14, 64'h6666, 1, 15);
    drive(1, 1, 13, 64'h5555, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      logic rst, wv, ev, rv;
      logic [4:0] wa, ea, ra;
      logic [63:0] wd, ed;
      rst = ($urandom_range(0, 59) != 0);
      wv = ($urandom_range(0, 9) < 7);
      ev = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ea = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom);
      ra = 5'($urandom);
      wd = {32'($urandom), 32'($urandom)};
      ed = {32'($urandom), 32'($urandom)};
      drive(rst, wv, wa, wd, ev, ea, ed, rv, ra);
    end
    idle(3);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive lost WB arbitration cycles before WB is forced to win.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 Port: wb_req_valid  in  1  pipeline writeback request.
REQ-005 Port: wb_req_addr  in  5  pipeline destination register.
REQ-006 Port: wb_req_data  in  64  pipeline write data.
REQ-007 Port: wb_req_ready  out  1  pipeline request accepted this cycle (combinational grant).
REQ-008 Port: ec_req_valid  in  1  ECALL result write request.
REQ-009 Port: ec_req_addr  in  5  ECALL destination register (normally x10).
REQ-010 Port: ec_req_data  in  64  ECALL result data.
REQ-011 Port: ec_req_ready  out  1  ECALL request accepted this cycle (combinational grant).
REQ-012 Port: reserve_valid  in  1  decode reserves a destination register.
REQ-013 Port: reserve_addr  in  5  register being reserved.
REQ-014 Port: rf_write_enable  out  1  registered register-file write strobe.
REQ-015 Port: rf_write_addr  out  5  registered register-file write address.
REQ-016 Port: rf_write_data  out  64  registered register-file write data.
REQ-017 Port: pending_mask  out  32  registered scoreboard; bit n = 1 means xn has an outstanding write.
REQ-018 Port: starve_count  out  3  registered count of consecutive WB losses, for debug.

Function
REQ-019 A handshake completes on a requester when its valid and ready are both 1 in the same cycle; at most one ready is 1 per cycle.
REQ-020 FSM states: PRIO_EC (ECALL wins a conflict) and PRIO_WB (WB wins a conflict); the reset state is PRIO_EC.
REQ-021 Only one requester valid: that requester is granted in the same cycle, in either state.
REQ-022 Both valid in PRIO_EC: ECALL is granted, and starve_count increments, saturating at STARVE_LIMIT.
REQ-023 When starve_count reaches STARVE_LIMIT, the FSM moves to PRIO_WB on the next edge.
REQ-024 Both valid in PRIO_WB: WB is granted.
REQ-025 Any WB grant clears starve_count to 0 and returns the FSM to PRIO_EC on the next edge.
REQ-026 Neither valid: no grant, starve_count holds, and the state holds.
REQ-027 Latency: a grant in cycle N drives rf_write_enable/addr/data with the granted request's values in cycle N+1; no grant in cycle N gives rf_write_enable=0 in N+1.
REQ-028 When rf_write_enable=0, rf_write_addr and rf_write_data hold their previous values.
REQ-029 x0 writes: the request is accepted (ready=1) but rf_write_enable stays 0 in N+1.
REQ-030 Scoreboard set: reserve_valid with reserve_addr != 0 sets that pending_mask bit on the next edge.
REQ-031 Scoreboard clear: when rf_write_enable=1, the rf_write_addr bit is cleared on the same edge that ends that cycle.
REQ-032 Reserve and clear of the same address on the same edge: set wins, and the bit stays 1.
REQ-033 pending_mask[0] is always 0.
REQ-034 A write to a register whose pending bit is 0 is still performed; the bit stays 0, and no error is flagged.
REQ-035 STARVE_LIMIT must be in the range 1..7, since starve_count is 3 bits wide.

Reset
REQ-036 While reset=0 at a clk edge, all state is cleared: rf_write_enable=0, rf_write_addr=0, rf_write_data=0, pending_mask=0, starve_count=0, FSM=PRIO_EC.
REQ-037 While reset=0, wb_req_ready=0 and ec_req_ready=0, and no handshake completes.
REQ-038 A request pending when reset asserts is dropped and must be re-presented after reset deasserts.
REQ-039 An output write registered in the cycle before reset asserts is cancelled by reset and never reaches the register file.

Verification
REQ-040 Bench case: WB alone, addr=5, data=0x1234 in cycle N -> wb_req_ready=1 in N; in N+1, rf_write_enable=1, addr=5, data=0x1234.
REQ-041 Bench case: both requesters valid for 6 cycles with STARVE_LIMIT=4 -> grants EC,EC,EC,EC,WB,EC; starve_count sequence 1,2,3,4,0,1.
REQ-042 Bench case: EC request with addr=0 -> ec_req_ready=1, rf_write_enable stays 0, pending_mask unchanged.
REQ-043 Bench case: reserve x7 in cycle N, then WB grant to x7 in N+2 -> pending_mask[7]=1 from N+1 through N+3, and 0 from N+4.
REQ-044 Bench case: reserve x9 on the same edge as the retiring write to x9 -> pending_mask[9] stays 1.
REQ-045 Bench case: grant in cycle N, reset=0 sampled at the end of N -> in N+1, rf_write_enable=0 and all outputs are 0; after release, the first request is granted normally.
